turn_signal_sequencer: RTL

Sequences the vehicle turn-signal LED banks from an internally divided step tick.
- Owns the step-rate divider: enables, clears and restarts it.
- Arbitrates left, right and hazard requests onto two LED banks.
- Drives a fill-sweep pattern; the board LED driver consumes `led_left` and `led_right` directly.

---
 rtl/turn_sig_pkg.sv | 34 +++
 rtl/step_prescaler.sv | 35 +++
 rtl/turn_signal_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/turn_sig_pkg.sv
// Shared definitions for the turn-signal sequencer.
// Provides the state encoding, the LED pattern generator (index -> bank mask)
// and the step-index width helper. No ports.
package turn_sig_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  // Width of a counter that must hold 0..steps-1. It is never narrower than 1 bit.
  function automatic int idx_width(input int steps);
    return (steps < 2) ? 1 : $clog2(steps);
  endfunction

  // Bank mask for a step index. Banks are at most 32 LEDs wide.
  // sweep=1: fill from bit0 up to bit idx, then dark hold steps.
  // sweep=0: plain blink, where index 0 lights every LED and index 1 lights none.
  function automatic logic [31:0] step_pattern(input int idx, input int led_w,
                                               input logic sweep);
    logic [32:0] fill;
    if (sweep) begin
      if (idx < led_w) fill = (33'd1 << (idx + 1)) - 33'd1;
      else             fill = '0;
    end else begin
      if (idx == 0) fill = (33'd1 << led_w) - 33'd1;
      else          fill = '0;
    end
    return fill[31:0];
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate divider: counts 0..CLK_DIV-1 while run is high and emits a
// registered one-cycle tick in the cycle the count sits at CLK_DIV-1.
// Ports: clk, rst_n (async, active-low), run (count enable),
//        clr (synchronous restart, wins over counting), tick (step pulse).
module step_prescaler #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr || !run) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == CNT_W'(CLK_DIV - 1)) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
      // Tick is raised on the same edge that loads CLK_DIV-1 into the count,
      // so the registered pulse lines up with that count value.
      tick <= (cnt == CNT_W'(CLK_DIV - 2));
    end
  end

endmodule

// File: rtl/turn_signal_sequencer.sv
// Turn-signal LED sequencer. It arbitrates left/right/hazard requests into a state
// and steps a pattern on two LED banks from an internal step divider.
// Build option: define TURN_SWEEP_EN for the fill-sweep pattern. When it is
// undefined, the banks blink, with all LEDs on for one step and off for one step.
// Ports: clk, rst_n (async, active-low), enable (0 forces IDLE),
//        left_req / right_req / hazard_req (level requests),
//        led_left / led_right (LED_W-wide banks, bit0 innermost),
//        step_tick (one-cycle step pulse), busy (state != IDLE).
module turn_signal_sequencer
  import turn_sig_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter int LED_W      = 8,
  parameter int HOLD_STEPS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             hazard_req,
  output logic [LED_W-1:0] led_left,
  output logic [LED_W-1:0] led_right,
  output logic             step_tick,
  output logic             busy
);

`ifdef TURN_SWEEP_EN
  localparam int   STEPS = LED_W + HOLD_STEPS;
  localparam logic SWEEP = 1'b1;
`else
  localparam int   STEPS = 2;
  localparam logic SWEEP = 1'b0;
`endif
  localparam int IDX_W = idx_width(STEPS);

  state_t           state;
  state_t           target;
  logic [IDX_W-1:0] idx;
  logic             tick;
  logic             run;
  logic             restart;
  logic [31:0]      mask;
  logic [LED_W-1:0] pattern;

  always_comb begin
    target = IDLE;
    if (!enable)                              target = IDLE;
    else if (hazard_req || (left_req && right_req)) target = HAZARD;
    else if (left_req)                        target = LEFT;
    else if (right_req)                       target = RIGHT;
  end

  // Any change of state restarts the divider and the pattern from step 0.
  assign restart = (target != state);
  assign run     = (state != IDLE);

  step_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (restart),
    .tick  (tick)
  );

  assign step_tick = tick;
  assign mask      = step_pattern(int'(idx), LED_W, SWEEP);
  assign pattern   = mask[LED_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      led_left  <= '0;
      led_right <= '0;
      busy      <= 1'b0;
    end else begin
      state <= target;
      busy  <= (target != IDLE);
      // The restart takes priority over a coincident tick, so the index lands on 0.
      if (restart)    idx <= '0;
      else if (tick)  idx <= (idx == IDX_W'(STEPS - 1)) ? '0 : idx + IDX_W'(1);
      // The banks show the current state/index one cycle later. Hazard drives both
      // banks from the same pattern, which keeps them phase-locked.
      led_left  <= (state == LEFT  || state == HAZARD) ? pattern : '0;
      led_right <= (state == RIGHT || state == HAZARD) ? pattern : '0;
    end
  end

endmodule
